// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A - B - Bin, LSB first, start/done handshake.
// Optional signed-overflow output enabled by SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
  , output logic           ovf
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, diff_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q, bout_q, busy_q, done_q;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q;
`endif

  logic             bit_d, br_d;
  logic [WIDTH-1:0] res_d;

  // Single full-subtractor cell on the current LSBs.
  always_comb begin
    bit_d = a_q[0] ^ b_q[0] ^ br_q;
    br_d  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    res_d = {bit_d, res_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_RUN: begin
          res_q <= res_d;
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= br_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            diff_q  <= res_d;
            bout_q  <= br_d;
`ifdef SERIAL_SUB_OVF_EN
            // br_q is the borrow into the MSB on this final bit.
            ovf_q   <= br_q ^ br_d;
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        default: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            br_q    <= Bin;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign Bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor (WIDTH=4).
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] A = '0, B = '0;
  logic       Bin = 1'b0;
  logic       busy, done, Bout;
  logic [3:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  int errors = 0;
  int checks = 0;
  int ndone;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .Bin(Bin),
    .busy(busy), .done(done), .diff(diff), .Bout(Bout)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nclk();
    @(negedge clk);
  endtask

  // Start one op, verify 4 busy cycles, done on the 5th, and single-cycle done.
  task automatic do_op(input string tag, input logic [3:0] a, input logic [3:0] b, input logic bi,
                       input logic [3:0] ed, input logic eb, input logic eo);
    A = a; B = b; Bin = bi; start = 1'b1;
    nclk();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check({tag, "_busy"}, 16'(busy), 16'd1);
      check({tag, "_nodone"}, 16'(done), 16'd0);
      nclk();
    end
    check({tag, "_done"}, 16'(done), 16'd1);
    check({tag, "_busy_lo"}, 16'(busy), 16'd0);
    check({tag, "_diff"}, 16'(diff), 16'(ed));
    check({tag, "_bout"}, 16'(Bout), 16'(eb));
`ifdef SERIAL_SUB_OVF_EN
    check({tag, "_ovf"}, 16'(ovf), 16'(eo));
`else
    if (eo) ; // ovf expectation only meaningful with the feature enabled
`endif
    nclk();
    check({tag, "_done_pulse"}, 16'(done), 16'd0);
  endtask

  initial begin
    nclk(); nclk();
    reset = 1'b0;
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_diff", 16'(diff), 16'd0);
    check("rst_bout", 16'(Bout), 16'd0);

    do_op("op7m3", 4'd7, 4'd3, 1'b0, 4'd4,  1'b0, 1'b0);
    do_op("op3m7", 4'd3, 4'd7, 1'b0, 4'hC,  1'b1, 1'b0);
    do_op("op0m0b", 4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0);
    do_op("op8m1", 4'd8, 4'd1, 1'b0, 4'd7,  1'b0, 1'b1);
    do_op("op5m2", 4'd5, 4'd2, 1'b0, 4'd3,  1'b0, 1'b0);
    do_op("op5m2b", 4'd5, 4'd2, 1'b1, 4'd2, 1'b0, 1'b0);
    do_op("op0mFb", 4'd0, 4'hF, 1'b1, 4'd0, 1'b1, 1'b0);

    // Start during RUN must be ignored.
    A = 4'd9; B = 4'd4; Bin = 1'b0; start = 1'b1;
    nclk();
    start = 1'b0;
    nclk();
    A = 4'd1; B = 4'd1; start = 1'b1;
    nclk();
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        ndone++;
        check("ign_diff", 16'(diff), 16'd5);
        check("ign_bout", 16'(Bout), 16'd0);
      end
      nclk();
    end
    check("ign_ndone", 16'(ndone), 16'd1);

    // Back-to-back with start held high.
    A = 4'd6; B = 4'd2; start = 1'b1;
    nclk();
    for (int i = 0; i < 4; i++) begin
      check("b2b_busy1", 16'(busy), 16'd1);
      nclk();
    end
    check("b2b_done1", 16'(done), 16'd1);
    check("b2b_diff1", 16'(diff), 16'd4);
    check("b2b_bout1", 16'(Bout), 16'd0);
    A = 4'd2; B = 4'd6;
    nclk();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("b2b_busy2", 16'(busy), 16'd1);
      check("b2b_nodone2", 16'(done), 16'd0);
      check("b2b_hold", 16'(diff), 16'd4);
      nclk();
    end
    check("b2b_done2", 16'(done), 16'd1);
    check("b2b_diff2", 16'(diff), 16'hC);
    check("b2b_bout2", 16'(Bout), 16'd1);
    nclk();

    // Reset during RUN discards the operation.
    A = 4'hF; B = 4'd1; start = 1'b1;
    nclk();
    start = 1'b0;
    nclk();
    reset = 1'b1;
    nclk();
    reset = 1'b0;
    check("mrst_busy", 16'(busy), 16'd0);
    check("mrst_done", 16'(done), 16'd0);
    check("mrst_diff", 16'(diff), 16'd0);
    check("mrst_bout", 16'(Bout), 16'd0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) ndone++;
      nclk();
    end
    check("mrst_nodone", 16'(ndone), 16'd0);
    do_op("opFm1", 4'hF, 4'd1, 1'b0, 4'hE, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
